// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-requester arbiter sharing the core-side memory bus between
// the instruction-fetch port (requester 0, "if") and the memory-stage data
// port (requester 1, "mem"). Ownership covers a whole transaction: it is taken
// in IDLE, held until the bus answers with ready or the owner drops valid, and
// always returns through IDLE, so there is one idle cycle between transactions.
//
// Optional feature, selected by the macro MEM_BUS_ARB_RR_EN:
//   defined   - round-robin on conflict: the requester that did not win the
//               last completed transaction is served first.
//   undefined - fixed priority: the data port beats fetch on every conflict.
// The last-winner register is kept in both builds so that switching the
// policy changes only the conflict decision.
module mem_bus_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,

  // fetch requester
  input  logic              mem_bus_arb_if_valid_i,
  input  logic [ADDR_W-1:0] mem_bus_arb_if_addr_i,
  input  logic [1:0]        mem_bus_arb_if_size_i,
  input  logic              mem_bus_arb_if_req_i,
  input  logic [DATA_W-1:0] mem_bus_arb_if_data_write_i,
  output logic              mem_bus_arb_if_ready_o,
  output logic [DATA_W-1:0] mem_bus_arb_if_data_read_o,
  output logic [1:0]        mem_bus_arb_if_resp_o,

  // data-port requester
  input  logic              mem_bus_arb_mem_valid_i,
  input  logic [ADDR_W-1:0] mem_bus_arb_mem_addr_i,
  input  logic [1:0]        mem_bus_arb_mem_size_i,
  input  logic              mem_bus_arb_mem_req_i,
  input  logic [DATA_W-1:0] mem_bus_arb_mem_data_write_i,
  output logic              mem_bus_arb_mem_ready_o,
  output logic [DATA_W-1:0] mem_bus_arb_mem_data_read_o,
  output logic [1:0]        mem_bus_arb_mem_resp_o,

  // downstream bus
  output logic              mem_bus_arb_bus_valid_o,
  output logic [ADDR_W-1:0] mem_bus_arb_bus_addr_o,
  output logic [1:0]        mem_bus_arb_bus_size_o,
  output logic              mem_bus_arb_bus_req_o,
  output logic [DATA_W-1:0] mem_bus_arb_bus_data_write_o,
  input  logic              mem_bus_arb_bus_ready_i,
  input  logic [DATA_W-1:0] mem_bus_arb_bus_data_read_i,
  input  logic [1:0]        mem_bus_arb_bus_resp_i,

  // one-hot owner: bit0 = if, bit1 = mem, 00 = idle
  output logic [1:0]        mem_bus_arb_grant_o
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_OWN_IF  = 2'b01;
  localparam logic [1:0] ST_OWN_MEM = 2'b10;

  localparam logic WIN_IF  = 1'b0;
  localparam logic WIN_MEM = 1'b1;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] conflict_state;

  // Pick the owner when both requesters ask in the same idle cycle.
  always_comb begin
    conflict_state = ST_OWN_MEM;
`ifdef MEM_BUS_ARB_RR_EN
    conflict_state = (last_q == WIN_MEM) ? ST_OWN_IF : ST_OWN_MEM;
`else
    conflict_state = ST_OWN_MEM;
`endif
  end

  // Ownership FSM: grant from IDLE, release on completion or owner abort.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_bus_arb_if_valid_i && mem_bus_arb_mem_valid_i) begin
          state_d = conflict_state;
        end else if (mem_bus_arb_if_valid_i) begin
          state_d = ST_OWN_IF;
        end else if (mem_bus_arb_mem_valid_i) begin
          state_d = ST_OWN_MEM;
        end
      end
      ST_OWN_IF: begin
        // ready wins over a simultaneous abort and counts as completion
        if (mem_bus_arb_bus_ready_i) begin
          state_d = ST_IDLE;
          last_d  = WIN_IF;
        end else if (!mem_bus_arb_if_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_MEM: begin
        if (mem_bus_arb_bus_ready_i) begin
          state_d = ST_IDLE;
          last_d  = WIN_MEM;
        end else if (!mem_bus_arb_mem_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Route the owner's request downstream and the bus response back to it only.
  always_comb begin
    mem_bus_arb_bus_valid_o      = 1'b0;
    mem_bus_arb_bus_addr_o       = '0;
    mem_bus_arb_bus_size_o       = '0;
    mem_bus_arb_bus_req_o        = 1'b0;
    mem_bus_arb_bus_data_write_o = '0;
    mem_bus_arb_if_ready_o       = 1'b0;
    mem_bus_arb_if_data_read_o   = '0;
    mem_bus_arb_if_resp_o        = '0;
    mem_bus_arb_mem_ready_o      = 1'b0;
    mem_bus_arb_mem_data_read_o  = '0;
    mem_bus_arb_mem_resp_o       = '0;
    case (state_q)
      ST_OWN_IF: begin
        mem_bus_arb_bus_valid_o      = mem_bus_arb_if_valid_i;
        mem_bus_arb_bus_addr_o       = mem_bus_arb_if_addr_i;
        mem_bus_arb_bus_size_o       = mem_bus_arb_if_size_i;
        mem_bus_arb_bus_req_o        = mem_bus_arb_if_req_i;
        mem_bus_arb_bus_data_write_o = mem_bus_arb_if_data_write_i;
        mem_bus_arb_if_ready_o       = mem_bus_arb_bus_ready_i;
        mem_bus_arb_if_data_read_o   = mem_bus_arb_bus_data_read_i;
        mem_bus_arb_if_resp_o        = mem_bus_arb_bus_resp_i;
      end
      ST_OWN_MEM: begin
        mem_bus_arb_bus_valid_o      = mem_bus_arb_mem_valid_i;
        mem_bus_arb_bus_addr_o       = mem_bus_arb_mem_addr_i;
        mem_bus_arb_bus_size_o       = mem_bus_arb_mem_size_i;
        mem_bus_arb_bus_req_o        = mem_bus_arb_mem_req_i;
        mem_bus_arb_bus_data_write_o = mem_bus_arb_mem_data_write_i;
        mem_bus_arb_mem_ready_o      = mem_bus_arb_bus_ready_i;
        mem_bus_arb_mem_data_read_o  = mem_bus_arb_bus_data_read_i;
        mem_bus_arb_mem_resp_o       = mem_bus_arb_bus_resp_i;
      end
      default: begin
        mem_bus_arb_bus_valid_o = 1'b0;
      end
    endcase
  end

  // State and last-winner registers; reset leaves fetch as the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= WIN_IF;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign mem_bus_arb_grant_o = state_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed self-checking bench for mem_bus_arb.
// Build with MEM_BUS_ARB_RR_EN defined to check the round-robin policy.
module tb_mem_bus_arb;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid, if_req, mem_valid, mem_req, bus_ready;
  logic [ADDR_W-1:0] if_addr, mem_addr;
  logic [1:0]        if_size, mem_size, bus_resp;
  logic [DATA_W-1:0] if_wdata, mem_wdata, bus_rdata;
  logic              if_ready, mem_ready, bus_valid, bus_req;
  logic [DATA_W-1:0] if_rdata, mem_rdata, bus_wdata;
  logic [1:0]        if_resp, mem_resp, bus_size, grant;
  logic [ADDR_W-1:0] bus_addr;

  int checks = 0;
  int errors = 0;

  mem_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .mem_bus_arb_if_valid_i       (if_valid),
    .mem_bus_arb_if_addr_i        (if_addr),
    .mem_bus_arb_if_size_i        (if_size),
    .mem_bus_arb_if_req_i         (if_req),
    .mem_bus_arb_if_data_write_i  (if_wdata),
    .mem_bus_arb_if_ready_o       (if_ready),
    .mem_bus_arb_if_data_read_o   (if_rdata),
    .mem_bus_arb_if_resp_o        (if_resp),
    .mem_bus_arb_mem_valid_i      (mem_valid),
    .mem_bus_arb_mem_addr_i       (mem_addr),
    .mem_bus_arb_mem_size_i       (mem_size),
    .mem_bus_arb_mem_req_i        (mem_req),
    .mem_bus_arb_mem_data_write_i (mem_wdata),
    .mem_bus_arb_mem_ready_o      (mem_ready),
    .mem_bus_arb_mem_data_read_o  (mem_rdata),
    .mem_bus_arb_mem_resp_o       (mem_resp),
    .mem_bus_arb_bus_valid_o      (bus_valid),
    .mem_bus_arb_bus_addr_o       (bus_addr),
    .mem_bus_arb_bus_size_o       (bus_size),
    .mem_bus_arb_bus_req_o        (bus_req),
    .mem_bus_arb_bus_data_write_o (bus_wdata),
    .mem_bus_arb_bus_ready_i      (bus_ready),
    .mem_bus_arb_bus_data_read_i  (bus_rdata),
    .mem_bus_arb_bus_resp_i       (bus_resp),
    .mem_bus_arb_grant_o          (grant)
  );

  always #5 clk = ~clk;

  // advance one cycle and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_valid = 1'b0; mem_valid = 1'b0; bus_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
    checks++; if (bus_addr !== 64'd0) begin errors++; $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); end
    checks++; if ({if_ready, mem_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {if_ready, mem_ready}); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_valid = 1'b1; if_addr = 64'h8000_0000; if_size = 2'd2; if_req = 1'b0;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL fetch_no_comb_path: got %b expected 0", bus_valid); end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL fetch_grant: got %b expected 01", grant); end
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL fetch_bus_valid: got %b expected 1", bus_valid); end
    checks++; if (bus_addr !== 64'h8000_0000) begin errors++; $display("FAIL fetch_bus_addr: got %h expected 80000000", bus_addr); end
    checks++; if (bus_size !== 2'd2) begin errors++; $display("FAIL fetch_bus_size: got %0d expected 2", bus_size); end
    step();
    step();
    bus_ready = 1'b1; bus_rdata = 64'h13; bus_resp = 2'b00;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready: got %b expected 1", if_ready); end
    checks++; if (if_rdata !== 64'h13) begin errors++; $display("FAIL fetch_rdata: got %h expected 13", if_rdata); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL fetch_mem_ready: got %b expected 0", mem_ready); end
    step();
    bus_ready = 1'b0; if_valid = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fetch_release: got %b expected 00", grant); end
  endtask

  task automatic test_conflict();
    logic [1:0] exp_seq [4];
`ifdef MEM_BUS_ARB_RR_EN
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    do_reset();
    if_valid = 1'b1; if_addr = 64'h100; mem_valid = 1'b1; mem_addr = 64'h200;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (grant !== exp_seq[i]) begin errors++; $display("FAIL conflict_grant_%0d: got %b expected %b", i, grant, exp_seq[i]); end
      bus_ready = 1'b1;
      step();
      bus_ready = 1'b0;
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL conflict_idle_%0d: got %b expected 00", i, grant); end
    end
    if_valid = 1'b0; mem_valid = 1'b0;
    step();
  endtask

  task automatic test_abort();
    do_reset();
    mem_valid = 1'b1; mem_addr = 64'h8000_1000; if_valid = 1'b1; if_addr = 64'h40;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL abort_grant_mem: got %b expected 10", grant); end
    checks++; if (bus_addr !== 64'h8000_1000) begin errors++; $display("FAIL abort_bus_addr: got %h expected 80001000", bus_addr); end
    mem_valid = 1'b0;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL abort_bus_valid: got %b expected 0", bus_valid); end
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b expected 00", grant); end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL abort_pending_if: got %b expected 01", grant); end
    checks++; if (bus_addr !== 64'h40) begin errors++; $display("FAIL abort_if_addr: got %h expected 40", bus_addr); end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0; if_valid = 1'b0;
    step();
  endtask

  task automatic test_isolation();
    do_reset();
    if_valid = 1'b1; if_addr = 64'h80;
    step();
    bus_ready = 1'b1; bus_resp = 2'b10; bus_rdata = 64'hDEAD_BEEF;
    #1;
    checks++; if (if_resp !== 2'b10) begin errors++; $display("FAIL iso_if_resp: got %b expected 10", if_resp); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL iso_mem_ready: got %b expected 0", mem_ready); end
    checks++; if (mem_resp !== 2'b00) begin errors++; $display("FAIL iso_mem_resp: got %b expected 00", mem_resp); end
    checks++; if (mem_rdata !== 64'd0) begin errors++; $display("FAIL iso_mem_rdata: got %h expected 0", mem_rdata); end
    step();
    if_valid = 1'b0;
    #1;
    checks++; if ({if_ready, mem_ready} !== 2'b00) begin errors++; $display("FAIL iso_idle_ready: got %b expected 00", {if_ready, mem_ready}); end
    checks++; if (if_resp !== 2'b00) begin errors++; $display("FAIL iso_idle_resp: got %b expected 00", if_resp); end
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL iso_idle_grant: got %b expected 00", grant); end
    bus_ready = 1'b0; bus_resp = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_valid = 1'b1; mem_addr = 64'h300;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rstmid_grant: got %b expected 10", grant); end
    rst = 1'b1;
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant_idle: got %b expected 00", grant); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rstmid_bus_valid: got %b expected 0", bus_valid); end
    checks++; if ({if_ready, mem_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_ready: got %b expected 00", {if_ready, mem_ready}); end
    rst = 1'b0; mem_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    if_valid = 1'b0; if_addr = '0; if_size = '0; if_req = 1'b0; if_wdata = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_size = '0; mem_req = 1'b0; mem_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0; bus_resp = '0;
    test_reset();
    test_single_fetch();
    test_conflict();
    test_abort();
    test_isolation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
